// File: rtl/acl_cursor_ctrl.sv
// Purpose : turns deglitched accelerometer X/Y tilt into a clamped, once-per-frame
//           cursor position (top-left pixel of a CUR_SIZE square sprite).
// Latency : frame_tick in cycle N -> cur_x valid N+3, cur_y and upd pulse at N+4.
// Backpr. : none; frame_tick arriving while busy is dropped, not queued.
//
// Ports:
//   CLK100MHZ  in   system clock
//   reset      in   synchronous, active-low
//   acl_data   in   {X[14:10],Y[9:5],Z[4:0]} 5-bit two's complement, asynchronous source
//   frame_tick in   1-cycle pulse at start of vertical blanking
//   cur_x      out  cursor left column, 0..H_RES-CUR_SIZE
//   cur_y      out  cursor top row,    0..V_RES-CUR_SIZE
//   upd        out  1-cycle pulse when cur_x/cur_y have just been updated
//   busy       out  high while the update sequence is in progress
module acl_cursor_ctrl #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int CUR_SIZE   = 8,
    parameter int DEAD_ZONE  = 2,
    parameter int STABLE_CNT = 4
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [14:0] acl_data,
    input  logic        frame_tick,
    output logic [9:0]  cur_x,
    output logic [9:0]  cur_y,
    output logic        upd,
    output logic        busy
);

    localparam int MAX_X = H_RES - CUR_SIZE;
    localparam int MAX_Y = V_RES - CUR_SIZE;
    localparam logic [9:0] MAX_X_L  = 10'(MAX_X);
    localparam logic [9:0] MAX_Y_L  = 10'(MAX_Y);
    localparam logic [9:0] INIT_X_L = 10'(MAX_X / 2);
    localparam logic [9:0] INIT_Y_L = 10'(MAX_Y / 2);
    localparam logic signed [11:0] DZ = 12'(DEAD_ZONE);

    // Counter saturates at STABLE_CNT-1; +1 keeps the width sane for tiny values.
    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CALC_X,
        S_CALC_Y,
        S_DONE
    } state_t;

    // Z never influences the cursor, so it is not even synchronised.
    logic unused_z;
    assign unused_z = ^acl_data[4:0];

    // Two-flop synchroniser plus one history stage for the stability compare.
    logic [9:0] sync1_q, sync1_d;
    logic [9:0] sync2_q, sync2_d;
    logic [9:0] prev_q,  prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // stable_q = {X, Y} as last accepted after STABLE_CNT equal samples.
    logic [9:0] stable_q, stable_d;

    state_t state_q, state_d;
    logic signed [11:0] vx_q, vx_d;
    logic signed [11:0] vy_q, vy_d;
    logic [9:0] cur_x_q, cur_x_d;
    logic [9:0] cur_y_q, cur_y_d;
    logic upd_q, upd_d;
    logic busy_q, busy_d;

    // Sign-extend a tilt field and zero it inside the dead zone.
    function automatic logic signed [11:0] vel(input logic [4:0] f);
        logic signed [11:0] v;
        v = {{7{f[4]}}, f};
        if ((v <= DZ) && (v >= -DZ)) begin
            v = '0;
        end
        return v;
    endfunction

    // Saturating add: results below 0 or above max stick to the edge.
    function automatic logic [9:0] step(input logic [9:0]         pos,
                                        input logic signed [11:0] delta,
                                        input logic [9:0]         max);
        logic signed [11:0] sum;
        logic [9:0]         res;
        sum = $signed({2'b00, pos}) + delta;
        if (sum < 12'sd0) begin
            res = '0;
        end else if (sum > $signed({2'b00, max})) begin
            res = max;
        end else begin
            res = sum[9:0];
        end
        return res;
    endfunction

    always_comb begin
        sync1_d  = {acl_data[14:10], acl_data[9:5]};
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        cnt_d    = '0;
        stable_d = stable_q;
        state_d  = state_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        upd_d    = 1'b0;
        busy_d   = busy_q;

        // Any change of the synchronised value restarts the stability count.
        if (sync2_q == prev_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        if (cnt_d == CNT_MAX) begin
            stable_d = sync2_q;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_LATCH;
                    busy_d  = 1'b1;
                end
            end
            S_LATCH: begin
                // Snapshot: later stable_q changes do not affect this frame.
                vx_d    = vel(stable_q[9:5]);
                vy_d    = vel(stable_q[4:0]);
                state_d = S_CALC_X;
            end
            S_CALC_X: begin
                cur_x_d = step(cur_x_q, vx_q, MAX_X_L);
                state_d = S_CALC_Y;
            end
            S_CALC_Y: begin
                // Positive Y tilt moves the cursor up the screen (smaller row).
                cur_y_d = step(cur_y_q, -vy_q, MAX_Y_L);
                upd_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            state_q  <= S_IDLE;
            vx_q     <= '0;
            vy_q     <= '0;
            cur_x_q  <= INIT_X_L;
            cur_y_q  <= INIT_Y_L;
            upd_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            upd_q    <= upd_d;
            busy_q   <= busy_d;
        end
    end

    assign cur_x = cur_x_q;
    assign cur_y = cur_y_q;
    assign upd   = upd_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_acl_cursor_ctrl.sv
// Purpose : directed bench for acl_cursor_ctrl with a position scoreboard.
// Latency : checks upd at exactly frame_tick+4 and cur_x/cur_y at +3/+4.
// Backpr. : none; also exercises dropped frame_tick and reset mid-update.
module tb_acl_cursor_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] acl_data;
    logic        frame_tick;
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic        upd;
    logic        busy;

    typedef struct {
        int x;
        int y;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   upd_seen = 0;
    int   ex       = 316;
    int   ey       = 236;

    acl_cursor_ctrl dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .acl_data  (acl_data),
        .frame_tick(frame_tick),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .upd       (upd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dz(input int v);
        return ((v <= 2) && (v >= -2)) ? 0 : v;
    endfunction

    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic logic [14:0] pk(input int x, input int y, input int z);
        logic [31:0] a, b, c;
        a = x;
        b = y;
        c = z;
        return {a[4:0], b[4:0], c[4:0]};
    endfunction

    // Scoreboard consumer: every upd pulse must match the oldest expected position.
    always @(negedge clk) begin
        if (upd === 1'b1) begin
            upd_seen++;
            chk("upd_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_cur_x", cur_x, e.x);
                chk("sb_cur_y", cur_y, e.y);
            end
        end
    end

    task automatic hold(input int x, input int y, input int n);
        acl_data = pk(x, y, 3);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_frame(input int vx, input int vy);
        exp_t e;
        ex  = clampi(ex + dz(vx), 632);
        ey  = clampi(ey - dz(vy), 472);
        e.x = ex;
        e.y = ey;
        exp_q.push_back(e);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("busy_n1", busy, 1);
        chk("upd_n1", upd, 0);
        @(negedge clk);
        @(negedge clk);
        chk("upd_n3", upd, 0);
        chk("cur_x_n3", cur_x, ex);
        @(negedge clk);
        chk("upd_n4", upd, 1);
        chk("cur_y_n4", cur_y, ey);
        @(negedge clk);
        chk("upd_n5", upd, 0);
        chk("busy_n5", busy, 0);
    endtask

    initial begin
        int u0;
        exp_t e;
        reset      = 1'b0;
        acl_data   = '0;
        frame_tick = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cur_x", cur_x, 316);
        chk("rst_cur_y", cur_y, 236);
        chk("rst_upd", upd, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);

        // Plain move right by 5
        hold(5, 0, 10);
        do_frame(5, 0);
        chk("t2_cur_x", cur_x, 321);

        // Both axes at the dead-zone edge: no move, upd still pulses
        hold(2, -2, 10);
        u0 = upd_seen;
        do_frame(2, -2);
        chk("t3_upd_once", upd_seen - u0, 1);
        chk("t3_cur_x", cur_x, 321);

        // Toggling input never becomes stable
        hold(0, 0, 10);
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    acl_data = pk((i % 2) ? -8 : 8, 0, 0);
                    repeat (2) @(negedge clk);
                end
                acl_data = pk(0, 0, 0);
            end
            begin
                repeat (8) @(negedge clk);
                do_frame(0, 0);
            end
        join
        chk("t5_cur_x", cur_x, 321);
        hold(0, 0, 10);

        // Clamping at all relevant edges
        hold(-16, 0, 10);
        for (int i = 0; i < 25; i++) do_frame(-16, 0);
        chk("t4_x_min", cur_x, 0);
        hold(15, 0, 10);
        for (int i = 0; i < 43; i++) do_frame(15, 0);
        chk("t4_x_max", cur_x, 632);
        hold(0, -16, 10);
        for (int i = 0; i < 20; i++) do_frame(0, -16);
        chk("t4_y_max", cur_y, 472);

        // Second frame_tick while busy is dropped
        hold(-3, 0, 10);
        u0   = upd_seen;
        ex   = clampi(ex - 3, 632);
        e.x  = ex;
        e.y  = ey;
        exp_q.push_back(e);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("t6_busy", busy, 1);
        @(negedge clk);
        chk("t6_upd_n4", upd, 1);
        chk("t6_cur_x", cur_x, 629);
        repeat (8) @(negedge clk);
        chk("t6_single_upd", upd_seen - u0, 1);

        // Reset during an update wins, no upd follows
        u0 = upd_seen;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ex = 316;
        ey = 236;
        chk("t6r_cur_x", cur_x, 316);
        chk("t6r_cur_y", cur_y, 236);
        chk("t6r_busy", busy, 0);
        chk("t6r_upd", upd, 0);
        repeat (8) @(negedge clk);
        chk("t6r_no_upd", upd_seen - u0, 0);
        chk("t6r_cur_x_hold", cur_x, 316);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
